// File: rtl/vga_pkg.sv
// 640x480@60 timing constants and the RGB888 pixel type shared with the picture generator.
// Pure definitions: no logic, no latency, no flow control.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_counter.sv
// Wrap counter 0..MAX-1 advancing on inc; wrap flags the last count while inc is high.
// cnt is registered, wrap is combinational; no stall beyond inc.
module vga_counter
    import vga_pkg::*;
#(
    parameter int MAX = 800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

    assign wrap = inc && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing plus registered pin stage; addresses/valid are same-cycle, pins lag by 1 clock.
// Free-running on the pixel clock: no enable, no stall, no backpressure.
module vga_timing_ctrl #(
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_pkg::H_FRONT,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_pkg::V_FRONT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);
    import vga_pkg::*;

    localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_HI   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_ACT_LO   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_active;
    logic       v_active;
    rgb_t       pix;

    vga_counter #(.MAX(H_TOT)) u_h_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    // The line counter steps once per completed line.
    vga_counter #(.MAX(V_TOT)) u_v_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    v_wrap_at_line_end: assert property (@(posedge clk) disable iff (!rst_n) v_wrap |-> h_wrap);

    assign h_active = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
    assign v_active = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
    assign valid    = h_active && v_active;

    // Addresses are forced to 0 in blanking so the subtraction never shows an underflow.
    assign h_addr = valid ? (h_cnt - H_ACT_LO) : 10'd0;
    assign v_addr = valid ? (v_cnt - V_ACT_LO) : 10'd0;

    assign pix = valid ? rgb_t'(vga_data) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !(h_cnt < H_SYNC_END);
            vsync       <= !(v_cnt < V_SYNC_END);
            blank_n     <= valid;
            vga_r       <= pix.r;
            vga_g       <= pix.g;
            vga_b       <= pix.b;
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: small-timing DUT checked every cycle against a raster model via a 1-deep scoreboard,
// plus table vectors, wrap/reset sequences, and a default-timing DUT checked up to its first active pixel.
module tb_vga_timing_ctrl;

    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 5, VF = 1;
    localparam int TH = HS + HB + HA + HF;
    localparam int TV = VS + VB + VA + VF;
    localparam int HLO = HS + HB, HHI = HS + HB + HA;
    localparam int VLO = VS + VB, VHI = VS + VB + VA;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
        logic        fs;
    } pins_t;

    typedef struct {
        int          h;
        int          v;
        logic [9:0]  ha;
        logic [9:0]  va;
        logic        vl;
        logic [23:0] nrgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] vga_s;
    logic [23:0] data_reg;
    logic [23:0] data_d;
    int          mode;

    logic [9:0] h_addr, v_addr;
    logic       valid, hsync, vsync, blank_n, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;

    logic [9:0] h_addr_d, v_addr_d;
    logic       valid_d, hsync_d, vsync_d, blank_n_d, frame_start_d;
    logic [7:0] vga_r_d, vga_g_d, vga_b_d;

    int    m_h = 0;
    int    m_v = 0;
    int    nchk = 0;
    int    nerr = 0;
    pins_t sb[$];
    vec_t  tbl[8];

    always #20 clk = ~clk;

    always_comb vga_s = (mode == 1) ? {4'h0, h_addr, v_addr} : data_reg;

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_data(vga_s),
        .h_addr(h_addr), .v_addr(v_addr), .valid(valid),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    vga_timing_ctrl dut_d (
        .clk(clk), .rst_n(rst_n), .vga_data(data_d),
        .h_addr(h_addr_d), .v_addr(v_addr_d), .valid(valid_d),
        .hsync(hsync_d), .vsync(vsync_d), .blank_n(blank_n_d),
        .vga_r(vga_r_d), .vga_g(vga_g_d), .vga_b(vga_b_d), .frame_start(frame_start_d)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic m_valid();
        return (m_h >= HLO) && (m_h < HHI) && (m_v >= VLO) && (m_v < VHI);
    endfunction

    // One clock: predict pins from the pre-edge model state, advance the model, compare at negedge.
    task automatic step();
        pins_t      e;
        logic       mv;
        logic [9:0] ha, va;
        @(posedge clk);
        if (!rst_n) begin
            e   = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, rgb: 24'h0, fs: 1'b0};
            m_h = 0;
            m_v = 0;
        end else begin
            mv    = m_valid();
            ha    = 10'(m_h - HLO);
            va    = 10'(m_v - VLO);
            e.hs  = !(m_h < HS);
            e.vs  = !(m_v < VS);
            e.bn  = mv;
            e.rgb = !mv ? 24'h0 : (mode == 1) ? {4'h0, ha, va} : data_reg;
            e.fs  = (m_h == 0) && (m_v == 0);
            if (m_h == TH - 1) begin
                m_h = 0;
                m_v = (m_v == TV - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("pins", {4'h0, hsync, vsync, blank_n, vga_r, vga_g, vga_b, frame_start}, {4'h0, e});
        mv = m_valid();
        chk("comb", {11'h0, valid, h_addr, v_addr},
            {11'h0, mv, mv ? 10'(m_h - HLO) : 10'd0, mv ? 10'(m_v - VLO) : 10'd0});
        if (mode == 2) data_reg = 24'($urandom);
    endtask

    task automatic wait_pos(input int h, input int v);
        logic found = 1'b0;
        for (int i = 0; i < 4 * TH * TV; i++) begin
            if (m_h == h && m_v == v) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("wait_pos", {31'h0, found}, 32'h1);
    endtask

    task automatic measure_period(input string nm);
        int p = 0;
        for (int i = 0; i < 2 * TH * TV; i++) begin
            step();
            p++;
            if (frame_start) break;
        end
        chk(nm, p, TH * TV);
    endtask

    initial begin
        int n_first, hl, vl, p, hs_lo, vs_lo, bl, good;
        rst_n    = 1'b0;
        mode     = 0;
        data_reg = 24'h103050;
        data_d   = 24'h103050;

        tbl[0] = '{h: 6,  v: 4, ha: 10'd0, va: 10'd0, vl: 1'b0, nrgb: 24'h000000};
        tbl[1] = '{h: 7,  v: 4, ha: 10'd0, va: 10'd0, vl: 1'b1, nrgb: 24'h000000};
        tbl[2] = '{h: 9,  v: 4, ha: 10'd2, va: 10'd0, vl: 1'b1, nrgb: 24'h000800};
        tbl[3] = '{h: 11, v: 5, ha: 10'd4, va: 10'd1, vl: 1'b1, nrgb: 24'h001001};
        tbl[4] = '{h: 10, v: 6, ha: 10'd3, va: 10'd2, vl: 1'b1, nrgb: 24'h000C02};
        tbl[5] = '{h: 14, v: 8, ha: 10'd7, va: 10'd4, vl: 1'b1, nrgb: 24'h001C04};
        tbl[6] = '{h: 15, v: 8, ha: 10'd0, va: 10'd0, vl: 1'b0, nrgb: 24'h000000};
        tbl[7] = '{h: 16, v: 9, ha: 10'd0, va: 10'd0, vl: 1'b0, nrgb: 24'h000000};

        repeat (3) step();
        chk("rst_pins", {hsync, vsync, blank_n, vga_r, vga_g, vga_b, frame_start}, {3'b110, 25'h0});
        chk("rst_pins_d", {hsync_d, vsync_d, blank_n_d, vga_r_d, frame_start_d}, {3'b110, 9'h0});
        rst_n = 1'b1;

        // Default 640x480 timing: run up to the first visible pixel.
        n_first = 0; hl = 0; vl = 0;
        for (int n = 1; n <= 30000; n++) begin
            step();
            if (n == 1) chk("dflt_first_fs", {31'h0, frame_start_d}, 32'h1);
            if (n <= 800 && !hsync_d) hl++;
            if (!vsync_d) vl++;
            if (blank_n_d) begin
                n_first = n;
                break;
            end
        end
        chk("dflt_first_active", n_first, 35 * 800 + 144 + 1);
        chk("dflt_hsync_low", hl, 96);
        chk("dflt_vsync_low", vl, 1600);
        chk("dflt_rgb", {vga_r_d, vga_g_d, vga_b_d}, 32'h103050);
        chk("dflt_addr", {valid_d, h_addr_d, v_addr_d}, {11'h0, 1'b1, 10'd1, 10'd0});

        // Small timing, constant colour: one full frame of pin statistics.
        p = 0;
        for (int i = 0; i < 2 * TH * TV; i++) begin
            if (frame_start) break;
            step();
        end
        chk("find_fs", {31'h0, frame_start}, 32'h1);
        hs_lo = 0; vs_lo = 0; bl = 0; good = 0;
        for (int i = 0; i < 2 * TH * TV; i++) begin
            hs_lo += int'(!hsync);
            vs_lo += int'(!vsync);
            bl    += int'(blank_n);
            good  += int'({vga_r, vga_g, vga_b} == (blank_n ? 24'h103050 : 24'h0));
            step();
            p++;
            if (frame_start) break;
        end
        chk("frame_period", p, TH * TV);
        chk("hsync_low_cycles", hs_lo, HS * TV);
        chk("vsync_low_cycles", vs_lo, VS * TH);
        chk("active_cycles", bl, HA * VA);
        chk("colour_gated", good, TH * TV);

        // Address-derived colour: table positions and next-cycle pin colour.
        mode = 1;
        foreach (tbl[i]) begin
            wait_pos(tbl[i].h, tbl[i].v);
            chk($sformatf("tbl%0d_addr", i), {valid, h_addr, v_addr},
                {11'h0, tbl[i].vl, tbl[i].ha, tbl[i].va});
            step();
            chk($sformatf("tbl%0d_rgb", i), {vga_r, vga_g, vga_b}, {8'h0, tbl[i].nrgb});
        end

        // Frame wrap and line increment.
        wait_pos(TH - 1, TV - 1);
        step();
        chk("wrap_fs_not_yet", {31'h0, frame_start}, 32'h0);
        step();
        chk("wrap_fs", {30'h0, frame_start, hsync}, 32'h2);
        wait_pos(TH - 1, 5);
        repeat (HLO + 1) step();
        chk("line_inc", {valid, h_addr, v_addr}, {11'h0, 1'b1, 10'd0, 10'd2});

        // Mid-line reset with random colour data.
        mode = 2;
        wait_pos(8, 6);
        rst_n = 1'b0;
        step();
        chk("midrst_pins", {hsync, vsync, blank_n, vga_r, vga_g, vga_b, frame_start}, {3'b110, 25'h0});
        chk("midrst_valid", {31'h0, valid}, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_fs", {30'h0, frame_start, hsync}, 32'h2);
        measure_period("post_rst_period");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
